// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci sweep controller: sweep FSM states and the
// buffered result entry layout at the default index/result widths.
package fib_pkg;

    localparam int FIB_N_W = 6;
    localparam int FIB_R_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PUSH,
        DRAIN
    } sweep_state_e;

    typedef struct packed {
        logic [FIB_N_W-1:0] n;
        logic [FIB_R_W-1:0] result;
        logic               overflow;
    } fib_entry_t;

endpackage

// File: rtl/fib_sweep_fifo.sv
// Small power-of-two FIFO with registered storage; head data reads as zero when empty.
module fib_sweep_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign push_ok = push && (count_reg != CNT_MAX);
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fib_sweep_ctrl.sv
// Sweeps a Fibonacci core over an index range [n_lo, n_hi] and streams each
// {n, result, overflow} through a small FIFO with valid/ready handshake.
module fib_sweep_ctrl
    import fib_pkg::*;
#(
    parameter int INPUT_WIDTH  = FIB_N_W,
    parameter int OUTPUT_WIDTH = FIB_R_W,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [INPUT_WIDTH-1:0]  n_lo,
    input  logic [INPUT_WIDTH-1:0]  n_hi,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    range_err,
    output logic                    fib_go,
    output logic [INPUT_WIDTH-1:0]  fib_n,
    input  logic [OUTPUT_WIDTH-1:0] fib_result,
    input  logic                    fib_overflow,
    input  logic                    fib_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUT_WIDTH-1:0]  out_n,
    output logic [OUTPUT_WIDTH-1:0] out_result,
    output logic                    out_overflow
);

    localparam int ENTRY_W = INPUT_WIDTH + OUTPUT_WIDTH + 1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]          DEPTH_C = FIFO_DEPTH[CW-1:0];
    localparam logic [INPUT_WIDTH-1:0] N_ONE   = 1;

    sweep_state_e           state_reg, state_next;
    logic [INPUT_WIDTH-1:0] cur_n_reg, cur_n_next;
    logic [INPUT_WIDTH-1:0] n_hi_reg, n_hi_next;
    logic                   range_err_reg, range_err_next;
    logic                   done_prev_reg;
    logic                   armed_reg;

    logic                   fifo_push;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [ENTRY_W-1:0]     fifo_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_n_reg     <= '0;
            n_hi_reg      <= '0;
            range_err_reg <= 1'b0;
            done_prev_reg <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_n_reg     <= cur_n_next;
            n_hi_reg      <= n_hi_next;
            range_err_reg <= range_err_next;
            done_prev_reg <= fib_done;
            // The first WAIT cycle may still see the previous request's done level.
            armed_reg     <= (state_reg == WAIT);
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_n_next     = cur_n_reg;
        n_hi_next      = n_hi_reg;
        range_err_next = range_err_reg;
        fib_go         = 1'b0;
        fifo_push      = 1'b0;
        sweep_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cur_n_next     = n_lo;
                    n_hi_next      = n_hi;
                    range_err_next = (n_lo > n_hi);
                    state_next     = (n_lo > n_hi) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (fifo_count < DEPTH_C) begin
                    fib_go     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (armed_reg && fib_done && !done_prev_reg) begin
                    state_next = PUSH;
                end
            end
            PUSH: begin
                fifo_push = 1'b1;
                // Equality terminates the sweep so cur_n never wraps at the top index.
                if (cur_n_reg == n_hi_reg) begin
                    state_next = DRAIN;
                end else begin
                    cur_n_next = cur_n_reg + N_ONE;
                    state_next = ISSUE;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    sweep_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE) && !sweep_done;
    assign range_err = range_err_reg;
    assign fib_n     = cur_n_reg;
    assign out_valid = !fifo_empty;
    assign {out_n, out_result, out_overflow} = fifo_rd_data;

    fib_sweep_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data ({cur_n_reg, fib_result, fib_overflow}),
        .pop     (out_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
// Directed bench for fib_sweep_ctrl with a stub core: done rises 5 cycles after go,
// result = 10*n, overflow = (n==7).
module tb_fib_sweep_ctrl;
    import fib_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  n_lo;
    logic [5:0]  n_hi;
    logic        busy;
    logic        sweep_done;
    logic        range_err;
    logic        fib_go;
    logic [5:0]  fib_n;
    logic [31:0] fib_result;
    logic        fib_overflow;
    logic        fib_done;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_n;
    logic [31:0] out_result;
    logic        out_overflow;

    int n_cmp = 0;
    int n_mis = 0;
    int go_cnt = 0;
    int cyc = 0;
    int first_rise = -1;
    int first_valid = -1;
    logic done_prev_tb = 1'b0;
    logic [2:0] stub_cnt;
    fib_entry_t got_q[$];

    fib_sweep_ctrl #(
        .INPUT_WIDTH  (6),
        .OUTPUT_WIDTH (32),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_lo         (n_lo),
        .n_hi         (n_hi),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .range_err    (range_err),
        .fib_go       (fib_go),
        .fib_n        (fib_n),
        .fib_result   (fib_result),
        .fib_overflow (fib_overflow),
        .fib_done     (fib_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_n        (out_n),
        .out_result   (out_result),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: done level drops on go, rises 5 cycles later, holds until next go.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fib_done     <= 1'b0;
            fib_result   <= '0;
            fib_overflow <= 1'b0;
            stub_cnt     <= '0;
        end else if (fib_go) begin
            fib_done     <= 1'b0;
            fib_result   <= 32'(fib_n) * 32'd10;
            fib_overflow <= (fib_n == 6'd7);
            stub_cnt     <= 3'd4;
        end else if (stub_cnt != 3'd0) begin
            stub_cnt <= stub_cnt - 3'd1;
            if (stub_cnt == 3'd1) fib_done <= 1'b1;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fib_go) go_cnt++;
        if (fib_done && !done_prev_tb && first_rise < 0) first_rise = cyc;
        if (out_valid && first_valid < 0) first_valid = cyc;
        done_prev_tb = fib_done;
        if (out_valid && out_ready) begin
            fib_entry_t e;
            e.n        = out_n;
            e.result   = out_result;
            e.overflow = out_overflow;
            got_q.push_back(e);
            $display("xfer: n=%0d result=%0d overflow=%0b", out_n, out_result, out_overflow);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_sweep(input logic [5:0] lo, input logic [5:0] hi, input bit expect_go);
        @(posedge clk); #1;
        start = 1'b1; n_lo = lo; n_hi = hi;
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("go_t1", 64'(fib_go), 64'(expect_go));
        check_eq("busy_t1", 64'(busy), 64'(expect_go));
        check_eq("done_t1", 64'(sweep_done), 64'(!expect_go));
        check_eq("rerr_t1", 64'(range_err), 64'(!expect_go));
        if (expect_go) check_eq("fib_n_t1", 64'(fib_n), 64'(lo));
        $display("start: lo=%0d hi=%0d go=%0b done=%0b", lo, hi, fib_go, sweep_done);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (sweep_done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_rerr"}, 64'(range_err), 64'd0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(sweep_done), 64'd0);
        $display("done: %s", tag);
    endtask

    task automatic check_stream(input string tag, input int lo, input int hi);
        check_eq({tag, "_count"}, 64'(got_q.size()), 64'(hi - lo + 1));
        for (int i = 0; i < got_q.size() && i <= hi - lo; i++) begin
            check_eq({tag, "_n"}, 64'(got_q[i].n), 64'(lo + i));
            check_eq({tag, "_res"}, 64'(got_q[i].result), 64'((lo + i) * 10));
            check_eq({tag, "_ovf"}, 64'(got_q[i].overflow), 64'((lo + i) == 7));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_lo = '0; n_hi = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(sweep_done), 64'd0);
        check_eq("rst_rerr", 64'(range_err), 64'd0);
        check_eq("rst_go", 64'(fib_go), 64'd0);
        check_eq("rst_fib_n", 64'(fib_n), 64'd0);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out", 64'({out_n, out_result, out_overflow}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // 3..5 with ready high, plus done-rise to out_valid latency
        got_q.delete(); go_cnt = 0; first_rise = -1; first_valid = -1;
        start_sweep(6'd3, 6'd5, 1'b1);
        wait_done("s35");
        check_stream("s35", 3, 5);
        check_eq("s35_gos", 64'(go_cnt), 64'd3);
        check_eq("s35_latency", 64'(first_valid - first_rise), 64'd2);

        // single index with overflow flagged
        got_q.delete(); go_cnt = 0;
        start_sweep(6'd7, 6'd7, 1'b1);
        wait_done("s77");
        check_stream("s77", 7, 7);

        // inverted range
        go_cnt = 0;
        start_sweep(6'd9, 6'd2, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("rerr_gos", 64'(go_cnt), 64'd0);
        check_eq("rerr_hold", 64'(range_err), 64'd1);
        check_eq("rerr_idle", 64'(busy), 64'd0);

        // back-pressure: FIFO fills to 4 and issue stalls
        got_q.delete(); go_cnt = 0; out_ready = 1'b0;
        start_sweep(6'd0, 6'd9, 1'b1);
        repeat (60) @(negedge clk);
        check_eq("bp_gos", 64'(go_cnt), 64'd4);
        check_eq("bp_valid", 64'(out_valid), 64'd1);
        check_eq("bp_head_n", 64'(out_n), 64'd0);
        check_eq("bp_busy", 64'(busy), 64'd1);
        check_eq("bp_rerr_clr", 64'(range_err), 64'd0);
        @(posedge clk); #1; out_ready = 1'b1;
        wait_done("s09");
        check_stream("s09", 0, 9);
        check_eq("s09_gos", 64'(go_cnt), 64'd10);

        // reset while waiting on the core mid-sweep
        go_cnt = 0;
        start_sweep(6'd0, 6'd9, 1'b1);
        for (int i = 0; i < 500 && go_cnt < 3; i++) @(negedge clk);
        check_eq("mid_gos", 64'(go_cnt), 64'd3);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_busy", 64'(busy), 64'd0);
        check_eq("mrst_go", 64'(fib_go), 64'd0);
        check_eq("mrst_fib_n", 64'(fib_n), 64'd0);
        check_eq("mrst_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_out", 64'({out_n, out_result, out_overflow}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        got_q.delete(); go_cnt = 0;
        start_sweep(6'd1, 6'd1, 1'b1);
        wait_done("s11");
        check_stream("s11", 1, 1);

        // start mid-sweep with other bounds must be ignored
        got_q.delete(); go_cnt = 0;
        start_sweep(6'd2, 6'd4, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; start = 1'b1; n_lo = 6'd10; n_hi = 6'd12;
        @(posedge clk); #1; start = 1'b0;
        wait_done("s24");
        check_stream("s24", 2, 4);
        check_eq("s24_gos", 64'(go_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
